// File: rtl/subword_engine.sv
// Sequential AES SubWord / key-expansion g() engine.
// LANES shared S-boxes substitute a 32-bit big-endian word over 4/LANES
// cycles. An optional RotWord is applied at capture and the Rcon XOR is
// folded into the last substitution cycle.

// Combinational AES S-box, table driven (byte a lives at bits 8a..8a+7).
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = TABLE[{a, 3'b000} +: 8];
endmodule

module subword_engine #(
  parameter int LANES  = 4,
  parameter bit ROT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] inp,
  input  logic        rot,
  input  logic [0:7]  rcon,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] out
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t                  state, state_nxt;
  logic [0:31]             w, w_in, w_sub;
  logic [0:7]              rc;
  logic [1:0]              idx;
  logic                    last, accept;
  logic [LANES-1:0][1:0]   sel;
  logic [LANES-1:0][7:0]   lane_in, lane_out;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("subword_engine: LANES must be 1, 2 or 4");
  end

  assign accept = in_valid && in_ready;
  assign last   = (idx == 2'(4 - LANES));
  assign out    = w;

  // RotWord is a pure rewire at capture; dropped entirely when disabled.
  if (ROT_EN) begin : g_rot
    assign w_in = rot ? {inp[8:31], inp[0:7]} : inp;
  end else begin : g_norot
    assign w_in = inp;
  end

  // Lane k substitutes byte idx+k; idx+k never exceeds 3.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign sel[k]     = idx + 2'(k);
    assign lane_in[k] = w[{sel[k], 3'b000} +: 8];
    sbox u_sbox (.a(lane_in[k]), .y(lane_out[k]));
  end

  // Merge substituted bytes back; Rcon lands on byte 0 in the final group.
  always_comb begin
    w_sub = w;
    for (int k = 0; k < LANES; k++)
      w_sub[{sel[k], 3'b000} +: 8] = lane_out[k];
    if (last)
      w_sub[0:7] = w_sub[0:7] ^ rc;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SUB;
      SUB:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Working word, captured Rcon and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      w   <= '0;
      rc  <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          w   <= w_in;
          rc  <= rcon;
          idx <= '0;
        end
        SUB: begin
          w   <= w_sub;
          idx <= idx + 2'(LANES);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_subword_engine.sv
// Bench for subword_engine: four instances (LANES 1/2/4 with RotWord, LANES 4
// without) checked against an S-box computed from GF(2^8) inversion + affine map.
module tb_subword_engine;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [ND];
  logic        ir   [ND];
  logic        rt   [ND];
  logic        ov   [ND];
  logic        ordy [ND];
  logic [0:31] inp  [ND];
  logic [0:31] outw [ND];
  logic [0:7]  rc   [ND];

  int n   = 0;
  int err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    subword_engine #(
      .LANES (g == 0 ? 1 : (g == 1 ? 2 : 4)),
      .ROT_EN(g == 3 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv[g]), .in_ready(ir[g]),
      .inp(inp[g]), .rot(rt[g]), .rcon(rc[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .out(outw[g])
    );
  end

  function automatic int lanes_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int s);
    return (b << s) | (b >> (8 - s));
  endfunction

  function automatic logic [7:0] sbox_ref(logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int i = 1; i < 256; i++)
        if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // g(): optional RotWord, SubWord on each byte, Rcon into the leading byte.
  function automatic logic [31:0] g_ref(logic [31:0] x, bit r, logic [7:0] c, int d);
    logic [31:0] y;
    if (r && d != 3) x = {x[23:0], x[31:24]};
    for (int b = 0; b < 4; b++) y[8*b +: 8] = sbox_ref(x[8*b +: 8]);
    y[31:24] = y[31:24] ^ c;
    return y;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transfer on instance d with 'hold' cycles of output back-pressure.
  task automatic xfer(int d, logic [31:0] x, bit r, logic [7:0] c, int hold, logic [31:0] exp);
    int lat, wt;
    logic [31:0] held;
    @(negedge clk);
    iv[d] = 1'b1; inp[d] = x; rt[d] = r; rc[d] = c; ordy[d] = 1'b0;
    wt = 0;
    while (!ir[d] && wt < 20) begin @(negedge clk); wt++; end
    chk("accept_ready", 32'(ir[d]), 32'd1);
    @(negedge clk);
    iv[d] = 1'b0; inp[d] = $urandom; rt[d] = 1'($urandom); rc[d] = 8'($urandom);
    chk("busy_not_ready", 32'(ir[d]), 32'd0);
    lat = 0;
    while (!ov[d] && lat < 20) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(4 / lanes_of(d)));
    chk("result", outw[d], exp);
    held = outw[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ov[d]), 32'd1);
      chk("hold_out", outw[d], held);
      chk("hold_ready", 32'(ir[d]), 32'd0);
    end
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    chk("taken_valid", 32'(ov[d]), 32'd0);
    chk("taken_ready", 32'(ir[d]), 32'd1);
  endtask

  initial begin
    int acc;
    bit prev;
    logic [31:0] got[$];
    for (int d = 0; d < ND; d++) begin
      iv[d] = 1'b1; rt[d] = 1'b0; ordy[d] = 1'b0; inp[d] = 32'hdeadbeef; rc[d] = 8'h5a;
    end

    // Reset held three cycles with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(ir[2]), 32'd0);
      chk("rst_valid", 32'(ov[2]), 32'd0);
      chk("rst_out", outw[2], 32'h0);
    end
    rst = 1'b0;
    for (int d = 0; d < ND; d++) iv[d] = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ir[2]), 32'd1);
    @(negedge clk);
    chk("post_rst_idle", 32'(ov[2]), 32'd0);

    // FIPS-197 g() on each width, plain SubWord, back-pressure.
    for (int d = 0; d < 3; d++) xfer(d, 32'h09CF4F3C, 1'b1, 8'h01, 0, 32'h8B84EB01);
    for (int d = 0; d < ND; d++) xfer(d, 32'h0053FF09, 1'b0, 8'h00, 0, 32'h63ED1601);
    xfer(2, 32'h09CF4F3C, 1'b1, 8'h01, 5, 32'h8B84EB01);

    // Reset two cycles into a LANES=1 operation.
    @(negedge clk);
    iv[0] = 1'b1; inp[0] = 32'h09CF4F3C; rt[0] = 1'b1; rc[0] = 8'h01; ordy[0] = 1'b1;
    chk("mid_rst_accept", 32'(ir[0]), 32'd1);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_no_valid", 32'(ov[0]), 32'd0);
      @(negedge clk);
    end
    ordy[0] = 1'b0;
    xfer(0, 32'h00000000, 1'b0, 8'h00, 0, 32'h63636363);

    // Back-to-back on the instance without RotWord, in_valid held high.
    @(negedge clk);
    iv[3] = 1'b1; rt[3] = 1'b1; rc[3] = 8'h00; inp[3] = 32'h09CF4F3C; ordy[3] = 1'b1;
    acc = 0; prev = 1'b0;
    for (int c = 0; c < 30 && (acc < 2 || got.size() < 2); c++) begin
      prev = iv[3] && ir[3];
      if (prev) acc++;
      if (ov[3] && ordy[3]) got.push_back(outw[3]);
      @(negedge clk);
      if (prev) begin
        if (acc == 1) inp[3] = 32'h00000000;
        else          iv[3] = 1'b0;
      end
    end
    iv[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ov[3] && ordy[3]) got.push_back(outw[3]);
      @(negedge clk);
    end
    ordy[3] = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_outputs", 32'(got.size()), 32'd2);
    while (got.size() < 2) got.push_back('x);
    chk("b2b_first", got[0], 32'h018A84EB);
    chk("b2b_second", got[1], 32'h63636363);

    // Randomised transfers against the reference model.
    for (int t = 0; t < 40; t++) begin
      int d;
      logic [31:0] x;
      bit r;
      logic [7:0] c;
      d = $urandom_range(0, ND - 1);
      x = $urandom;
      r = 1'($urandom);
      c = 8'($urandom);
      xfer(d, x, r, c, $urandom_range(0, 2), g_ref(x, r, c, d));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
